// File: rtl/somsub_pkg.sv
// Shared types and opcode constants for the serial adder/subtractor.
package somsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} somsub_estado_t;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/somsub_digito.sv
// Combinational DIGIT-bit ripple slice; cmsb is the carry into the top bit of the slice.
module somsub_digito
    import somsub_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b_mod,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]       = a[i] ^ b_mod[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_mod[i]) | (carry[i] & (a[i] ^ b_mod[i]));
    end

    assign cout = carry[DIGIT];
    assign cmsb = carry[DIGIT-1];

endmodule

// File: rtl/somador_subtrator_serial.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock, LSB first.
// Define SOMSUB_FLAGS_EN to build the V (signed overflow) and Z (zero) flags.
module somador_subtrator_serial
    import somsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Te,
    input  logic             M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Ts,
    output logic             V,
    output logic             Z
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N + 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_err
        $error("somador_subtrator_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    somsub_estado_t   estado_q, estado_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             m_q, m_d;
    logic             c_q, c_d;
    logic             ts_q, ts_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] sum_next;

    somsub_digito #(
        .DIGIT(DIGIT)
    ) u_digito (
        .a    (a_q[DIGIT-1:0]),
        .b_mod(b_q[DIGIT-1:0]),
        .cin  (c_q),
        .s    (slice_s),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // New digit enters at the MSB end so the finished word lines up after N shifts.
    assign sum_next = (sum_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

`ifdef SOMSUB_FLAGS_EN
    logic v_q, v_d;
    logic z_q, z_d;
`endif

    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        c_d      = c_q;
        ts_d     = ts_q;
`ifdef SOMSUB_FLAGS_EN
        v_d      = v_q;
        z_d      = z_q;
`endif
        unique case (estado_q)
            IDLE, DONE: begin
                if (start) begin
                    estado_d = RUN;
                    a_d      = A;
                    b_d      = (M == OP_SUB) ? ~B : B;
                    m_d      = M;
                    c_d      = Te ^ M;
                    cnt_d    = '0;
                end else begin
                    estado_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = slice_cout;
                sum_d = sum_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    estado_d = DONE;
                    s_d      = sum_next;
                    ts_d     = slice_cout ^ m_q;
`ifdef SOMSUB_FLAGS_EN
                    v_d      = slice_cout ^ slice_cmsb;
                    z_d      = ~|sum_next;
`endif
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            m_q      <= 1'b0;
            c_q      <= 1'b0;
            ts_q     <= 1'b0;
`ifdef SOMSUB_FLAGS_EN
            v_q      <= 1'b0;
            z_q      <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            c_q      <= c_d;
            ts_q     <= ts_d;
`ifdef SOMSUB_FLAGS_EN
            v_q      <= v_d;
            z_q      <= z_d;
`endif
        end
    end

    assign busy = (estado_q == RUN);
    assign done = (estado_q == DONE);
    assign S    = s_q;
    assign Ts   = ts_q;

`ifdef SOMSUB_FLAGS_EN
    assign V = v_q;
    assign Z = z_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = slice_cmsb;
    assign V = 1'b0;
    assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Four instances (DIGIT = 1, 2, 4, 8) checked against an arithmetic model of {Ts, S, V, Z}.
module tb_somador_subtrator_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0;
    logic [7:0] a_i = '0;
    logic [7:0] b_i = '0;
    logic       te_i = 1'b0;
    logic       m_i = 1'b0;

    logic [3:0] busy_w, done_w, ts_w, v_w, z_w;
    logic [7:0] s_w [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        somador_subtrator_serial #(
            .WIDTH(8),
            .DIGIT(1 << g)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start_v[g]),
            .A    (a_i),
            .B    (b_i),
            .Te   (te_i),
            .M    (m_i),
            .busy (busy_w[g]),
            .done (done_w[g]),
            .S    (s_w[g]),
            .Ts   (ts_w[g]),
            .V    (v_w[g]),
            .Z    (z_w[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic m,
                                  input logic te, output logic [7:0] s, output logic ts,
                                  output logic v, output logic z);
        int sa, sb, r, ur;
        sa = $signed(a);
        sb = $signed(b);
        if (!m) begin
            ur = int'(a) + int'(b) + int'(te);
            ts = (ur > 255);
            r  = sa + sb + int'(te);
        end else begin
            ur = int'(a) - int'(b) - int'(te);
            ts = (ur < 0);
            r  = sa - sb - int'(te);
        end
        s = 8'(ur);
`ifdef SOMSUB_FLAGS_EN
        v = (r > 127) || (r < -128);
        z = (s == 8'h00);
`else
        v = 1'b0;
        z = 1'b0;
`endif
    endfunction

    // inj: 0 plain, 1 spurious start while busy, 2 reset mid-run, 3 back-to-back start in DONE
    task automatic run_op(input logic [3:0] mask, input logic [7:0] a, input logic [7:0] b,
                          input logic m, input logic te, input int inj);
        int         first_lat [4];
        int         last_lat  [4];
        int         pulses    [4];
        logic [7:0] s_first [4], s_last [4];
        logic       ts_first [4], v_first [4], z_first [4];
        logic       ts_last [4], v_last [4], z_last [4];
        logic [7:0] es, es2;
        logic       ets, ev, ez, ets2, ev2, ez2;
        logic [7:0] a2, b2;
        int         window;

        a2 = ~a;
        b2 = b + 8'd5;
        model(a, b, m, te, es, ets, ev, ez);
        model(a2, b2, ~m, te, es2, ets2, ev2, ez2);
        window = (inj == 3) ? 20 : 12;
        for (int i = 0; i < 4; i++) begin
            first_lat[i] = -1;
            last_lat[i]  = -1;
            pulses[i]    = 0;
        end

        @(negedge clk);
        a_i = a; b_i = b; m_i = m; te_i = te; start_v = mask;
        @(posedge clk);
        #1;
        start_v = '0;
        a_i = $urandom; b_i = $urandom;
        for (int i = 0; i < 4; i++)
            if (mask[i]) check_eq($sformatf("d%0d_busy_after_start", i), 32'(busy_w[i]), 32'd1);

        for (int e = 1; e <= window; e++) begin
            if ((inj == 1 && e == 3) || (inj == 3 && e == 9)) begin
                a_i = a2; b_i = b2; m_i = ~m; te_i = te; start_v = mask;
            end
            if (inj == 2 && e == 4) rst = 1'b1;
            @(posedge clk);
            #1;
            start_v = '0;
            if (inj == 2 && e == 4) begin
                rst = 1'b0;
                check_eq("rst_mid_busy", 32'(busy_w[0]), 32'd0);
                check_eq("rst_mid_s", 32'(s_w[0]), 32'd0);
            end
            for (int i = 0; i < 4; i++) begin
                if (done_w[i]) begin
                    pulses[i]++;
                    if (first_lat[i] < 0) begin
                        first_lat[i] = e;
                        s_first[i] = s_w[i]; ts_first[i] = ts_w[i];
                        v_first[i] = v_w[i]; z_first[i] = z_w[i];
                    end
                    last_lat[i] = e;
                    s_last[i] = s_w[i]; ts_last[i] = ts_w[i];
                    v_last[i] = v_w[i]; z_last[i] = z_w[i];
                    check_eq($sformatf("d%0d_busy_in_done", i), 32'(busy_w[i]), 32'd0);
                end
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (!mask[i]) continue;
            if (inj == 2) begin
                check_eq($sformatf("d%0d_no_done_after_rst", i), 32'(pulses[i]), 32'd0);
                check_eq($sformatf("d%0d_s_after_rst", i), 32'(s_w[i]), 32'd0);
            end else begin
                check_eq($sformatf("d%0d_pulses", i), 32'(pulses[i]), (inj == 3) ? 32'd2 : 32'd1);
                check_eq($sformatf("d%0d_latency", i), 32'(first_lat[i]), 32'(8 >> i));
                check_eq($sformatf("d%0d_S", i), 32'(s_first[i]), 32'(es));
                check_eq($sformatf("d%0d_Ts", i), 32'(ts_first[i]), 32'(ets));
                check_eq($sformatf("d%0d_V", i), 32'(v_first[i]), 32'(ev));
                check_eq($sformatf("d%0d_Z", i), 32'(z_first[i]), 32'(ez));
                if (inj == 3) begin
                    check_eq($sformatf("d%0d_b2b_latency", i), 32'(last_lat[i]), 32'd17);
                    check_eq($sformatf("d%0d_b2b_S", i), 32'(s_last[i]), 32'(es2));
                    check_eq($sformatf("d%0d_b2b_Ts", i), 32'(ts_last[i]), 32'(ets2));
                    check_eq($sformatf("d%0d_b2b_V", i), 32'(v_last[i]), 32'(ev2));
                    check_eq($sformatf("d%0d_b2b_Z", i), 32'(z_last[i]), 32'(ez2));
                end
                check_eq($sformatf("d%0d_S_held", i), 32'(s_w[i]), (inj == 3) ? 32'(es2) : 32'(es));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("d%0d_rst_busy", i), 32'(busy_w[i]), 32'd0);
            check_eq($sformatf("d%0d_rst_done", i), 32'(done_w[i]), 32'd0);
            check_eq($sformatf("d%0d_rst_S", i), 32'(s_w[i]), 32'd0);
            check_eq($sformatf("d%0d_rst_Ts", i), 32'(ts_w[i]), 32'd0);
            check_eq($sformatf("d%0d_rst_V", i), 32'(v_w[i]), 32'd0);
            check_eq($sformatf("d%0d_rst_Z", i), 32'(z_w[i]), 32'd0);
        end
        rst = 1'b0;

        run_op(4'hF, 8'd100, 8'd27, 1'b0, 1'b0, 0);
        run_op(4'hF, 8'd5,   8'd7,  1'b1, 1'b0, 0);
        run_op(4'hF, 8'd0,   8'd0,  1'b1, 1'b1, 0);
        run_op(4'hF, 8'd127, 8'd1,  1'b0, 1'b0, 0);
        run_op(4'hF, 8'h80,  8'd1,  1'b1, 1'b0, 0);
        run_op(4'hF, 8'hFF,  8'd1,  1'b0, 1'b0, 0);
        run_op(4'hF, 8'hF0,  8'h10, 1'b0, 1'b0, 0);
        run_op(4'hF, 8'hFF,  8'hFF, 1'b0, 1'b1, 0);

        run_op(4'h1, 8'd100, 8'd27, 1'b0, 1'b0, 1);
        run_op(4'h1, 8'd77,  8'd200, 1'b1, 1'b1, 3);
        run_op(4'h1, 8'd33,  8'd44, 1'b0, 1'b1, 2);
        run_op(4'hF, 8'd33,  8'd44, 1'b0, 1'b1, 0);

        for (int k = 0; k < 1000; k++)
            run_op(4'hF, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
